// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and defaults for the fetch PC unit.
// Next-PC select encoding plus default width, step and reset address.
package fetch_pkg;

  typedef enum logic [2:0] {
    SEL_HOLD,
    SEL_REDIR,
    SEL_PEND,
    SEL_RET,
    SEL_CALL,
    SEL_SEQ
  } sel_e;

  localparam int unsigned DEF_ADDR_W   = 16;
  localparam int unsigned DEF_STEP     = 1;
  localparam int unsigned DEF_RESET_PC = 0;

endpackage

// File: rtl/fetch_pc_unit_ras_stack.sv
// ras_stack: circular return-address stack for the fetch PC unit.
// A push when full overwrites the oldest entry; count saturates.
module ras_stack
  import fetch_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int RAS_DEPTH = 4,
  localparam int PW = $clog2(RAS_DEPTH),
  localparam int CW = PW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_addr,
  output logic [ADDR_W-1:0] top,
  output logic [CW-1:0]     count,
  output logic              empty,
  output logic              full
);

  logic [ADDR_W-1:0] mem [RAS_DEPTH];
  logic [PW-1:0]     ptr;
  logic [PW-1:0]     ptr_m1;

  assign ptr_m1 = ptr - PW'(1);
  assign top    = mem[ptr_m1];
  assign empty  = (count == '0);
  assign full   = (count == CW'(RAS_DEPTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr   <= '0;
      count <= '0;
    end else if (push) begin
      ptr <= ptr + PW'(1);
      if (!full) count <= count + CW'(1);
    end else if (pop && !empty) begin
      ptr   <= ptr_m1;
      count <= count - CW'(1);
    end
  end

  // Entries need no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[ptr] <= push_addr;
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: fetch-stage PC with prioritised redirects and halt capture.
// Return-address stack present only when FETCH_RAS_EN is defined.
module fetch_pc_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int RAS_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC),
  parameter logic [ADDR_W-1:0] STEP     = ADDR_W'(DEF_STEP),
  localparam int CW = $clog2(RAS_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hlt,
  input  logic              redirect_en,
  input  logic [ADDR_W-1:0] redirect_addr,
  input  logic              call_en,
  input  logic [ADDR_W-1:0] call_target,
  input  logic              ret_en,
  output logic [ADDR_W-1:0] pc,
  output logic [CW-1:0]     ras_count,
  output logic              ras_underflow,
  output logic              pend_valid
);

  sel_e              sel;
  logic [ADDR_W-1:0] pc_seq;
  logic [ADDR_W-1:0] pc_nxt;
  logic [ADDR_W-1:0] pend_addr;
  logic [ADDR_W-1:0] ras_top;
  logic              ras_empty;
  logic              ret_req;

  assign pc_seq = pc + STEP;

`ifdef FETCH_RAS_EN
  logic push;
  logic pop;
  logic ras_full_unused;

  assign ret_req = ret_en;
  assign push    = (sel == SEL_CALL);
  assign pop     = (sel == SEL_RET) && !ras_empty;

  ras_stack #(
    .ADDR_W   (ADDR_W),
    .RAS_DEPTH(RAS_DEPTH)
  ) u_ras (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .push_addr(pc_seq),
    .top      (ras_top),
    .count    (ras_count),
    .empty    (ras_empty),
    .full     (ras_full_unused)
  );

  always_ff @(posedge clk) begin
    if (rst) ras_underflow <= 1'b0;
    else     ras_underflow <= (sel == SEL_RET) && ras_empty;
  end
`else
  logic unused_ret;

  assign unused_ret    = ret_en;
  assign ret_req       = 1'b0;
  assign ras_empty     = 1'b1;
  assign ras_top       = '0;
  assign ras_count     = '0;
  assign ras_underflow = 1'b0;
`endif

  // A return outranks a call fetched in the same cycle.
  always_comb begin
    sel = SEL_SEQ;
    if (hlt)              sel = SEL_HOLD;
    else if (redirect_en) sel = SEL_REDIR;
    else if (pend_valid)  sel = SEL_PEND;
    else if (ret_req)     sel = SEL_RET;
    else if (call_en)     sel = SEL_CALL;
  end

  always_comb begin
    pc_nxt = pc_seq;
    unique case (sel)
      SEL_HOLD:  pc_nxt = pc;
      SEL_REDIR: pc_nxt = redirect_addr;
      SEL_PEND:  pc_nxt = pend_addr;
      SEL_RET:   pc_nxt = ras_empty ? pc_seq : ras_top;
      SEL_CALL:  pc_nxt = call_target;
      default:   pc_nxt = pc_seq;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= RESET_PC;
      pend_valid <= 1'b0;
      pend_addr  <= '0;
    end else begin
      pc <= pc_nxt;
      if (hlt && redirect_en) begin
        pend_valid <= 1'b1;
        pend_addr  <= redirect_addr;
      end else if (sel == SEL_REDIR || sel == SEL_PEND) begin
        pend_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Parametrised program-counter generator for the fetch stage. It holds the PC, advances it sequentially, and applies external redirects with a fixed priority. Redirects that arrive during a halt are remembered and applied when the halt ends. A return-address stack (RAS) serves call/return; the RAS can be compiled out. The block sits at the head of the pipeline and drives the instruction-memory address.

## Interface
Parameters:
- ADDR_W, 16: PC / address width.
- RAS_DEPTH, 4: RAS entries; power of two, ≥2.
- RESET_PC, 0: PC value after reset.
- STEP, 1: sequential increment.

Ports:
- clk  in  1: clock; all state updates on posedge.
- rst  in  1: reset; synchronous, active-high.
- hlt  in  1: hold PC (stall).
- redirect_en  in  1: redirect request (mispredict / exception).
- redirect_addr  in  ADDR_W: redirect target.
- call_en  in  1: call fetched; jump to call_target, push pc+STEP.
- call_target  in  ADDR_W: call destination.
- ret_en  in  1: return fetched; jump to RAS top, pop.
- pc  out  ADDR_W: current fetch address (registered).
- ras_count  out  $clog2(RAS_DEPTH)+1: valid RAS entries.
- ras_underflow  out  1: one-cycle pulse, ret_en with empty RAS.
- pend_valid  out  1: a redirect is captured and waiting.

## Operation
- Reset: pc=RESET_PC, ras_count=0, ras_underflow=0, pend_valid=0, pend_addr=0, RAS pointer=0. rst overrides every other input.
- Next-PC priority, evaluated each cycle when rst=0:
  1. hlt=1: pc holds. call_en and ret_en are ignored; the RAS is unchanged. If redirect_en=1, pend_valid<=1 and pend_addr<=redirect_addr. A later redirect during the same halt overwrites pend_addr.
  2. redirect_en=1: pc<=redirect_addr; pend_valid<=0. A new redirect beats a pending one.
  3. pend_valid=1: pc<=pend_addr; pend_valid<=0.
  4. ret_en=1: pc<=RAS top and pop. If the RAS is empty: pc<=pc+STEP, ras_underflow pulses, count stays 0.
  5. call_en=1: pc<=call_target; push pc+STEP.
  6. otherwise: pc<=pc+STEP.
- call_en and ret_en asserted together: ret wins; the call is dropped (no push).
- Calls and returns are ignored in any cycle where priority 2 or 3 applies. The RAS is never flushed by a redirect.
- RAS is circular:
  - push writes at ptr, then ptr+1 mod RAS_DEPTH; count saturates at RAS_DEPTH.
  - push when full overwrites the oldest entry.
  - pop reads ptr-1, then ptr-1; count decrements.
- Arithmetic is modulo 2^ADDR_W: pc+STEP wraps from all-ones to low values silently, with no flag.

## Timing
- Inputs are sampled at posedge; pc reflects the decision one cycle later. There is no combinational path from inputs to pc.
- ras_underflow is high exactly one cycle, the cycle after the offending ret_en.
- A pending redirect is applied on the first posedge with hlt=0, so the PC is visible one cycle after hlt drops.
- A halt of any length loses no redirect and adds no extra latency.
- rst asserted mid-halt or mid-pending: everything returns to reset values on that edge; the pending redirect is discarded.

## Configuration
- FETCH_RAS_EN defined: RAS present as described above.
- FETCH_RAS_EN undefined:
  - no RAS storage.
  - call_en behaves as a redirect to call_target at priority 5, with no push.
  - ret_en is ignored, so the PC advances sequentially.
  - ras_count is tied to 0 and ras_underflow to 0.
  - RAS_DEPTH is unused.

## Structure
- Package fetch_pkg holds:
  - next-PC select enum: SEL_HOLD, SEL_REDIR, SEL_PEND, SEL_RET, SEL_CALL, SEL_SEQ.
  - default ADDR_W, STEP and RESET_PC constants.
- One sub-module, ras_stack (parameters ADDR_W, RAS_DEPTH): push/pop/top/count/empty/full, with synchronous rst. It is instantiated only under FETCH_RAS_EN.
- The top level holds the priority select, pc register and pending-redirect register.

## Test plan
- Reset release, no inputs for 3 cycles -> pc = 0, 1, 2, 3.
- hlt=1 at pc=5; redirect_en pulse to 0x40, then to 0x80 during the halt; release hlt -> pc holds 5, pend_valid=1, and pc=0x80 one cycle after release.
- pc=0x10, call_en to 0x200, then ret_en -> pc=0x200, ras_count=1, then pc=0x11, ras_count=0.
- With RAS_DEPTH=4: 5 nested calls, then 5 returns -> the first 4 returns give the latest 4 return addresses; the 5th returns pc+1 with a ras_underflow pulse.
- Simultaneous: call_en+ret_en with RAS holding 0x33 -> pc=0x33, no push. Simultaneous redirect_en+ret_en -> pc=redirect_addr and ras_count unchanged.
- pc=0xFFFF (ADDR_W=16), no inputs -> pc=0x0000. Then rst during hlt with pend_valid=1 -> pc=RESET_PC and pend_valid=0.
